// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, controller state encoding, legal round
// counts and the GF(2^8) / byte-placement helpers used by the datapath blocks.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

  // State byte (row, col) sits at byte index row+4*col, byte 0 in the top bits.
  function automatic int unsigned byte_msb(input int unsigned row, input int unsigned col);
    return AES_BLK_W - 1 - 8 * (row + 4 * col);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] result
);

  logic [AES_BLK_W-1:0] added;
  logic [AES_BLK_W-1:0] mixed;

  always_comb begin
    added = '0;
    mixed = '0;
    // Row r rotates right by r, so output column c takes input column c-r.
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        added[byte_msb(r, c) -: 8] = inv_sbox(state[byte_msb(r, (c + 4 - r) % 4) -: 8])
                                     ^ rk[byte_msb(r, c) -: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        mixed[byte_msb(r, c) -: 8] = gmul(added[byte_msb(r, c) -: 8], 8'h0e)
                                   ^ gmul(added[byte_msb((r + 1) % 4, c) -: 8], 8'h0b)
                                   ^ gmul(added[byte_msb((r + 2) % 4, c) -: 8], 8'h0d)
                                   ^ gmul(added[byte_msb((r + 3) % 4, c) -: 8], 8'h09);
      end
    end
    result = last ? added : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock through a shared
// aes_inv_round, round keys fetched by index, valid/ready on both sides.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR       = 10,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [AES_BLK_W-1:0] rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_nr_check
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end

  ctrl_state_e           fsm_q;
  ctrl_state_e           fsm_d;
  logic [RK_IDX_W-1:0]   rcnt_q;
  logic [AES_BLK_W-1:0]  data_q;
  logic [AES_BLK_W-1:0]  round_out;
  logic                  last;

  // Exit is decoded at zero before any decrement, so rcnt never wraps.
  assign last = (rcnt_q == '0);

  aes_inv_round u_round (
    .state  (data_q),
    .rk     (rk),
    .last   (last),
    .result (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (in_valid) fsm_d = ST_ROUND;
      ST_ROUND: if (last)     fsm_d = ST_DONE;
      ST_DONE:  if (out_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = RK_IDX_W'(NR);
      end
      ST_ROUND: begin
        busy   = 1'b1;
        rk_idx = rcnt_q;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rcnt_q <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            data_q <= in_data ^ rk;
            rcnt_q <= RK_IDX_W'(NR - 1);
          end
        end
        ST_ROUND: begin
          data_q <= round_out;
          if (!last) rcnt_q <= rcnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: FIPS-197 vectors plus random blocks produced
// by a forward AES model, on an NR=10 and an NR=14 instance.
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, rk_a, out_data_a;
  logic [3:0]   rk_idx_a;
  logic         rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, rk_b, out_data_b;
  logic [3:0]   rk_idx_b;

  logic [127:0] rk_tab [0:1][0:14];
  logic [7:0]   sbox [0:255];
  int checks = 0;
  int errors = 0;

  assign rk_a = rk_tab[0][rk_idx_a];
  assign rk_b = rk_tab[1][rk_idx_b];

  aes_inv_cipher_ctrl #(.NR(10), .RK_IDX_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .rk_idx(rk_idx_a), .rk(rk_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a)
  );

  aes_inv_cipher_ctrl #(.NR(14), .RK_IDX_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .rk_idx(rk_idx_b), .rk(rk_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    logic [7:0] r;
    r = (x << s) | (x >> (8 - s));
    return r;
  endfunction

  // S-box from the generator-3 walk: p steps by *3, q by /3, sbox[p]=affine(q).
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int which);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++)
      rk_tab[which][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic encrypt(input logic [127:0] pt, input int nr, input int which,
                         output logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] k;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk_tab[which][0][127 - 8 * i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd != nr) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      k = rk_tab[which][rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
  endtask

  task automatic accept_a(input logic [127:0] ct);
    int n;
    in_data_a  = ct;
    in_valid_a = 1'b1;
    n = 0;
    while (!in_ready_a && n < 100) begin step; n++; end
    chk("accept_ready", in_ready_a, 1);
    step;
    in_valid_a = 1'b0;
  endtask

  task automatic wait_out_a(input logic [127:0] exp, input string tag);
    int c;
    c = 1;
    while (!out_valid_a && c < 60) begin step; c++; end
    chk({tag, "_latency"}, c, 11);
    chk({tag, "_pt"}, out_data_a, exp);
  endtask

  task automatic retire_a;
    out_ready_a = 1'b1;
    step;
    out_ready_a = 1'b0;
    chk("retire_out_valid", out_valid_a, 0);
    chk("retire_in_ready", in_ready_a, 1);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] pt, ct, pt2, ct2;
    logic [255:0] key;
    int c, nb, lat;
    bit seen;

    rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    build_sbox();
    expand({C1_KEY, 128'h0}, 4, 0);
    step; step;
    rst_a = 1'b0; rst_b = 1'b0;
    chk("reset_in_ready", in_ready_a, 1);
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_out_data", out_data_a, '0);
    chk("reset_rk_idx", rk_idx_a, 10);

    // C.1 with the full round-key index sequence and exact latency
    in_data_a  = C1_CT;
    in_valid_a = 1'b1;
    chk("c1_rk_idx_idle", rk_idx_a, 10);
    step;
    in_valid_a = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      chk("c1_rk_idx_round", rk_idx_a, k);
      chk("c1_no_early_valid", out_valid_a, 0);
      chk("c1_in_ready_low", in_ready_a, 0);
      step;
    end
    chk("c1_out_valid", out_valid_a, 1);
    chk("c1_pt", out_data_a, C1_PT);
    retire_a();

    // Appendix B
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 0);
    accept_a(128'h3925841d02dc09fbdc118597196a0b32);
    wait_out_a(128'h3243f6a8885a308d313198a2e0370734, "appb");
    retire_a();

    // Random keys and plaintexts through the forward model
    for (int i = 0; i < 4; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      expand(key, 4, 0);
      pt = {$urandom, $urandom, $urandom, $urandom};
      encrypt(pt, 10, 0, ct);
      accept_a(ct);
      wait_out_a(pt, "rand");
      retire_a();
    end

    // Backpressure: output held 20 cycles while a second block waits
    expand({C1_KEY, 128'h0}, 4, 0);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    encrypt(pt2, 10, 0, ct2);
    accept_a(C1_CT);
    wait_out_a(C1_PT, "bp1");
    in_data_a  = ct2;
    in_valid_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_out_data", out_data_a, C1_PT);
      chk("bp_in_ready", in_ready_a, 0);
    end
    out_ready_a = 1'b1;
    step;
    out_ready_a = 1'b0;
    chk("bp_retire_valid", out_valid_a, 0);
    chk("bp_idle_busy", busy_a, 0);
    chk("bp_idle_in_ready", in_ready_a, 1);
    step;
    in_valid_a = 1'b0;
    chk("bp_second_accepted", busy_a, 1);
    wait_out_a(pt2, "bp2");
    retire_a();

    // Back-to-back with out_ready tied high
    pt = {$urandom, $urandom, $urandom, $urandom};
    encrypt(pt, 10, 0, ct);
    out_ready_a = 1'b1;
    in_data_a   = ct;
    in_valid_a  = 1'b1;
    step;
    in_data_a = ct2;
    c = 1;
    seen = 1'b0;
    while (!in_ready_a && c < 60) begin
      if (out_valid_a) begin
        chk("b2b_pt1", out_data_a, pt);
        seen = 1'b1;
      end
      step;
      c++;
    end
    chk("b2b_pt1_seen", seen, 1);
    chk("b2b_accept_spacing", c, 12);
    step;
    in_valid_a = 1'b0;
    wait_out_a(pt2, "b2b2");
    step;
    out_ready_a = 1'b0;
    chk("b2b_idle", in_ready_a, 1);

    // Reset in round 5 discards the block
    accept_a(C1_CT);
    step; step; step; step;
    chk("rst_mid_round5", rk_idx_a, 5);
    rst_a = 1'b1;
    step;
    rst_a = 1'b0;
    chk("rst_mid_in_ready", in_ready_a, 1);
    chk("rst_mid_out_valid", out_valid_a, 0);
    chk("rst_mid_busy", busy_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid_a || busy_a) seen = 1'b1;
      step;
    end
    chk("rst_mid_no_output", seen, 0);
    accept_a(C1_CT);
    wait_out_a(C1_PT, "rst_c1");
    retire_a();

    // Reset wins over a same-cycle accept
    in_data_a  = C1_CT;
    in_valid_a = 1'b1;
    rst_a      = 1'b1;
    step;
    rst_a      = 1'b0;
    in_valid_a = 1'b0;
    chk("rst_prio_busy", busy_a, 0);
    chk("rst_prio_in_ready", in_ready_a, 1);

    // NR=14: C.3 then a random 256-bit key
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1);
        ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        pt = C1_PT;
      end else begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand(key, 8, 1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        encrypt(pt, 14, 1, ct);
      end
      in_data_b  = ct;
      in_valid_b = 1'b1;
      nb = 0;
      while (!in_ready_b && nb < 100) begin step; nb++; end
      chk("nr14_accept_ready", in_ready_b, 1);
      step;
      in_valid_b = 1'b0;
      lat = 1;
      while (!out_valid_b && lat < 60) begin step; lat++; end
      chk("nr14_latency", lat, 15);
      chk("nr14_pt", out_data_b, pt);
      out_ready_b = 1'b1;
      step;
      out_ready_b = 1'b0;
      chk("nr14_retire", out_valid_b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
